serial_word_comparator: RTL and testbench

Compares two wide unsigned operands using a single 4-bit cascade compare slice, one nibble per clock. It works from the least significant nibble to the most significant, carrying eq/gt/lt between nibbles. It is used where a full-width comparator is too costly and multi-cycle latency is acceptable. Requesters use a start/busy/done handshake and read registered eq/gt/lt flags.

---
 rtl/serial_word_comparator_pkg.sv | 12 +
 rtl/serial_word_comparator_cmp_nibble_cascade.sv | 23 ++
 rtl/serial_word_comparator.sv | 118 +++++++++++
 tb/tb_serial_word_comparator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_comparator_pkg.sv
// rtl/serial_word_comparator_pkg.sv - shared constants and FSM encoding for the serial comparator
package serial_word_comparator_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_word_comparator_cmp_nibble_cascade.sv
// rtl/serial_word_comparator_cmp_nibble_cascade.sv - one 4-bit compare slice with eq/gt/lt carry
// A difference in this nibble overrides whatever the lower nibbles decided.
module cmp_nibble_cascade
  import serial_word_comparator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                eq_in,
  input  logic                gt_in,
  input  logic                lt_in,
  output logic                eq_out,
  output logic                gt_out,
  output logic                lt_out
);

  logic nib_eq;

  assign nib_eq = (a == b);
  assign eq_out = nib_eq & eq_in;
  assign gt_out = (a > b) | (gt_in & nib_eq);
  assign lt_out = (a < b) | (lt_in & nib_eq);

endmodule

// File: rtl/serial_word_comparator.sv
// rtl/serial_word_comparator.sv - multi-cycle unsigned compare, one nibble per clock, LSB first
// Result flags are registered and held until the next compare completes or reset.
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic                         eq,
  output logic                         gt,
  output logic                         lt
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q, b_q;
  logic             eq_c_q, gt_c_q, lt_c_q;
  logic             eq_q, gt_q, lt_q;
  logic             accept, last;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic                eq_n, gt_n, lt_n;

  for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
    assign a_nib[n] = a_q[n*NIBBLE_W +: NIBBLE_W];
    assign b_nib[n] = b_q[n*NIBBLE_W +: NIBBLE_W];
  end

  cmp_nibble_cascade u_slice (
    .a      (a_nib[idx_q]),
    .b      (b_nib[idx_q]),
    .eq_in  (eq_c_q),
    .gt_in  (gt_c_q),
    .lt_in  (lt_c_q),
    .eq_out (eq_n),
    .gt_out (gt_n),
    .lt_out (lt_n)
  );

  // DONE accepts a new start exactly like IDLE so requests can run back to back.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      eq_c_q  <= 1'b0;
      gt_c_q  <= 1'b0;
      lt_c_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        idx_q  <= '0;
        eq_c_q <= 1'b1;
        gt_c_q <= 1'b0;
        lt_c_q <= 1'b0;
      end else if (state_q == RUN) begin
        eq_c_q <= eq_n;
        gt_c_q <= gt_n;
        lt_c_q <= lt_n;
        idx_q  <= last ? '0 : idx_q + IDX_W'(1);
      end
      if (last) begin
        eq_q <= eq_n;
        gt_q <= gt_n;
        lt_q <= lt_n;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb/tb_serial_word_comparator.sv - randomized and directed bench for serial_word_comparator
module tb_serial_word_comparator;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic         busy, done, eq, gt, lt;

  int   checks   = 0;
  int   failures = 0;
  logic exp_eq = 1'b0, exp_gt = 1'b0, exp_lt = 1'b0;

  always #5 clk = ~clk;

  serial_word_comparator #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".eq"}, 32'(eq), 32'(exp_eq));
    check({tag, ".gt"}, 32'(gt), 32'(exp_gt));
    check({tag, ".lt"}, 32'(lt), 32'(exp_lt));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check_flags(tag);
  endtask

  // noise: 0 none, 1 a=b=0 restart attempt two cycles in, 2 random start/operand churn
  task automatic do_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int noise);
    int lat;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      check("run.busy", 32'(busy), 32'd1);
      check_flags("run.hold");
      if (noise == 1 && lat == 1) begin
        start = 1'b1;
        a     = '0;
        b     = '0;
      end else if (noise == 2) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'(NIBBLES));
    exp_eq = (ta == tb_v);
    exp_gt = (ta > tb_v);
    exp_lt = (ta < tb_v);
    check("done.pulse", 32'(done), 32'd1);
    check("done.busy", 32'(busy), 32'd0);
    check_flags("done");
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check_idle("reset");
    tick();
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    do_compare(16'h1234, 16'h1234, 0);
    tick();
    check_idle("after_eq");

    do_compare(16'h8000, 16'h7FFF, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle_hold");
    end

    do_compare(16'h1233, 16'h1234, 0);
    do_compare(16'h0001, 16'h0000, 0);
    tick();
    check_idle("after_b2b");

    do_compare(16'hFFFF, 16'h0000, 1);
    tick();
    check_idle("ignored_start");

    start = 1'b1;
    a     = 16'h5555;
    b     = 16'h5555;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    exp_eq = 1'b0;
    exp_gt = 1'b0;
    exp_lt = 1'b0;
    check_idle("async_reset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle("post_abort");
    end
    do_compare(16'h1234, 16'h1234, 0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIBBLES - 1)));
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [W-1:0] t;
        t  = ra;
        ra = rb;
        rb = t;
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("rand_gap");
      end
      do_compare(ra, rb, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
    tick();
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
